uart_tx_flex: RTL and testbench

Parametrised UART transmitter: it serialises one word per valid/ready handshake into a frame of start, data (LSB first), optional parity and stop bits on a single mark-idle line. It sits between the MLP result/debug formatter and the board UART pin. It replaces the fixed 8N1, edge-triggered sender with configurable frame format, input latching and a completion pulse. The baud divider is a compile-time parameter, so one instance serves each PLL-derived clock.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_tx_flex.sv | 142 ++++++++++++++
 tb/tb_uart_tx_flex.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and the future receiver:
// FSM state encoding, parity mode constants and the baud counter width.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int BAUD_W = 16;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV while enabled and flags the last count.
// Held at zero while disabled so every frame starts on a full bit period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 234
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [BAUD_W-1:0] cnt;

  assign tick = en && (cnt == BAUD_W'(CLK_DIV));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_flex.sv
// Configurable UART transmitter: start, DATA_BITS LSB-first, optional parity,
// STOP_BITS stop bits. Parity is compiled in with the UART_TX_PARITY_EN macro.
module uart_tx_flex
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 234,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 uart_tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BIT_W = $clog2(DATA_BITS);

  uart_state_t          state, state_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_nxt;
  logic                 stop_cnt, stop_nxt;
  logic [DATA_BITS-1:0] sh, sh_nxt;
  logic                 line_nxt;
  logic                 done_nxt;
  logic                 accept;
  logic                 tick;
`ifdef UART_TX_PARITY_EN
  logic                 par, par_nxt;
`endif

  assign tx_ready = (state == IDLE);
  assign tx_busy  = !tx_ready;
  assign accept   = tx_valid && tx_ready;

  uart_baud_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (state != IDLE),
    .tick (tick)
  );

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    stop_nxt  = stop_cnt;
    sh_nxt    = sh;
    done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par;
`endif
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = START;
          sh_nxt    = tx_data;
          bit_nxt   = '0;
          stop_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_nxt   = (^tx_data) ^ (PARITY_ODD == int'(PAR_ODD));
`endif
        end
      end
      START: begin
        if (tick) state_nxt = DATA;
      end
      DATA: begin
        if (tick) begin
          sh_nxt = sh >> 1;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
            stop_nxt = 1'b0;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            stop_nxt = stop_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Line level follows the next state so it switches on the same edge.
    line_nxt = 1'b1;
    unique case (state_nxt)
      START:   line_nxt = 1'b0;
      DATA:    line_nxt = sh_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_nxt = par_nxt;
`endif
      default: line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      uart_tx  <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_nxt;
      stop_cnt <= stop_nxt;
      uart_tx  <= line_nxt;
      tx_done  <= done_nxt;
    end
  end

  // Payload registers carry no reset; they are reloaded on every acceptance.
  always_ff @(posedge clk) begin
    sh  <= sh_nxt;
`ifdef UART_TX_PARITY_EN
    par <= par_nxt;
`endif
  end

endmodule

// File: tb/tb_uart_tx_flex.sv
// Bench for uart_tx_flex: frame-level reference model checked every cycle,
// plus literal frame captures for the directed cases.
module tb_uart_tx_flex;

  localparam int CD = 3;
  localparam int N  = CD + 1;
`ifdef UART_TX_PARITY_EN
  localparam int DB = 7;
  localparam int SB = 2;
  localparam int P  = 1;
`else
  localparam int DB = 8;
  localparam int SB = 1;
  localparam int P  = 0;
`endif
  localparam int PO   = 0;
  localparam int FLEN = 1 + DB + P + SB;
  localparam int F    = FLEN * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, uart_tx, tx_busy, tx_done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  uart_tx_flex #(
    .CLK_DIV(CD), .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .uart_tx(uart_tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of line levels, each held N clocks.
  bit   m_busy = 0;
  bit   m_done = 0;
  bit   m_acc  = 0;
  int   m_k    = 0;
  logic m_frame [0:15];

  function automatic void build(input logic [DB-1:0] d);
    int idx;
    m_frame[0] = 1'b0;
    for (int i = 0; i < DB; i++) m_frame[1+i] = d[i];
    idx = 1 + DB;
    if (P == 1) begin
      m_frame[idx] = (^d) ^ (PO == 1);
      idx++;
    end
    for (int s = 0; s < SB; s++) m_frame[idx+s] = 1'b1;
  endfunction

  always @(posedge clk) begin
    m_done = 0;
    m_acc  = 0;
    if (!rst_n) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (tx_valid) begin
        build(tx_data);
        m_busy = 1;
        m_acc  = 1;
        m_k    = 0;
      end
    end else begin
      m_k++;
      if (m_k == F) begin
        m_busy = 0;
        m_done = 1;
      end
    end
  end

  always @(negedge rst_n) begin
    m_busy = 0;
    m_done = 0;
  end

  always @(negedge clk) begin
    chk("uart_tx", {31'b0, uart_tx}, {31'b0, m_busy ? m_frame[m_k / N] : 1'b1});
    chk("tx_ready", {31'b0, tx_ready}, {31'b0, !m_busy});
    chk("tx_busy", {31'b0, tx_busy}, {31'b0, m_busy});
    chk("tx_done", {31'b0, tx_done}, {31'b0, m_done});
    if (tx_done) done_cnt++;
  end

  task automatic send(input logic [15:0] d, input bit hold);
    bit ok = 0;
    tx_data  = d[DB-1:0];
    tx_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (m_acc) ok = 1;
    end
    if (!hold) tx_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // Captures the middle of each bit period and the cycle of tx_done.
  task automatic run_frame(input logic [15:0] d, input int poke_k, input logic [15:0] poke,
                           output logic [15:0] lv);
    int done_at = -1;
    lv = '0;
    send(d, 1'b0);
    for (int k = 0; k <= F + 1; k++) begin
      if (k == poke_k) tx_data = poke[DB-1:0];
      if (k % N == 1 && k / N < FLEN) lv[k / N] = uart_tx;
      if (tx_done && done_at < 0) done_at = k;
      @(negedge clk);
    end
    chk("done_cycle", done_at, F);
  endtask

  initial begin
    logic [15:0] lv;
    int gap, d0, l40, l41;

    // Reset with a word offered: nothing may be accepted.
    tx_valid = 1'b1;
    tx_data  = '1;
    repeat (5) @(negedge clk);
    chk("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    chk("rst_ready", {31'b0, tx_ready}, 32'd1);
    chk("rst_busy", {31'b0, tx_busy}, 32'd0);
    chk("rst_done", {31'b0, tx_done}, 32'd0);
    tx_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (2) @(negedge clk);

`ifdef UART_TX_PARITY_EN
    run_frame(16'h41, -1, 16'h0, lv);
    chk("frame_41", {21'b0, lv[10:0]}, {21'b0, 11'b11010000010});
`else
    run_frame(16'hA5, -1, 16'h0, lv);
    chk("frame_a5", {22'b0, lv[9:0]}, {22'b0, 10'b1101001010});
    run_frame(16'h3C, 10, 16'hFF, lv);
    chk("frame_3c_latched", {22'b0, lv[9:0]}, {22'b0, 10'b1001111000});
`endif

    // Back-to-back with valid held high.
    d0 = done_cnt;
    send(16'h00, 1'b1);
    tx_data = '1;
    gap = -1; l40 = 0; l41 = 0;
    for (int k = 1; k < 200 && gap < 0; k++) begin
      @(negedge clk);
      if (k == F)     l40 = uart_tx;
      if (k == F + 1) l41 = uart_tx;
      if (m_acc) gap = k;
    end
    tx_valid = 1'b0;
    chk("b2b_gap", gap, F + 1);
    chk("b2b_line_EF", l40, 1);
    chk("b2b_line_EF1", l41, 0);
    repeat (F + 3) @(negedge clk);
    chk("b2b_done_pulses", done_cnt - d0, 2);

    // Reset during data bit 3 (line low for 0xA5).
    send(16'hA5, 1'b0);
    repeat (4 * N + 1) @(negedge clk);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_line", {31'b0, uart_tx}, 32'd1);
    chk("midrst_ready", {31'b0, tx_ready}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (F) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    run_frame(16'h5A, -1, 16'h0, lv);
`ifndef UART_TX_PARITY_EN
    chk("frame_5a", {22'b0, lv[9:0]}, {22'b0, 10'b1010110100});
`endif

    // Random offers and data churn, checked every cycle by the model.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      tx_valid = ($urandom_range(0, 9) < 3);
      tx_data  = DB'($urandom);
    end
    tx_valid = 1'b0;
    repeat (F + 3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
